// File: rtl/tmds_pkg.sv
// TMDS control tokens, alignment FSM encoding and token lookup.
// Shared by the receive decoder and the transmit encoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] SLIP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
  } tok_t;

  function automatic tok_t tok_to_ctrl(input logic [9:0] sym);
    tok_t t;
    t = '{is_ctrl: 1'b0, ctrl: 2'b00};
    unique case (1'b1)
      (sym == CTRL_TOK_00): t = '{is_ctrl: 1'b1, ctrl: 2'b00};
      (sym == CTRL_TOK_01): t = '{is_ctrl: 1'b1, ctrl: 2'b01};
      (sym == CTRL_TOK_10): t = '{is_ctrl: 1'b1, ctrl: 2'b10};
      (sym == CTRL_TOK_11): t = '{is_ctrl: 1'b1, ctrl: 2'b11};
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_decoder_symbol_decode.sv
// Symbol classify and data decode with the 1-cycle output register.
// The ctrl flag is also exported combinationally for the aligner.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] sym_i,
  output logic       is_ctrl_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  tok_t       tok;
  logic [7:0] d;
  logic [7:0] dec;

  logic       de_d,   de_q;
  logic [1:0] ctrl_d, ctrl_q;
  logic [7:0] data_d, data_q;

  assign tok = tok_to_ctrl(sym_i);
  assign d   = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];

  always_comb begin
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_i[8] ? (d[i] ^ d[i-1])
                        : ~(d[i] ^ d[i-1]);
    end
  end

  // Whichever field the symbol does not carry keeps its last value
  always_comb begin
    de_d   = ~tok.is_ctrl;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (tok.is_ctrl) ctrl_d = tok.ctrl;
    else             data_d = dec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_q   <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign is_ctrl_o = tok.is_ctrl;
  assign de_o      = de_q;
  assign ctrl_o    = ctrl_q;
  assign data_o    = data_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder with control-token word aligner (bitslip FSM).
// Define TMDS_LOSS_CNT_EN to add the O_loss_cnt lock-loss counter.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_LOCK_CNT = 64,
  parameter int SEARCH_WIN    = 4096,
  parameter int SLIP_SETTLE   = 8,
  parameter int LOSS_WIN      = 8192
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst,
  input  logic [9:0]  I_sym,
  output logic        O_bitslip,
  output logic        O_aligned,
  output logic        O_de,
  output logic [1:0]  O_ctrl,
  output logic [7:0]  O_data
`ifdef TMDS_LOSS_CNT_EN
  ,
  output logic [15:0] O_loss_cnt
`endif
);

  localparam int MAX_AB = (CTRL_LOCK_CNT > SEARCH_WIN)
                        ? CTRL_LOCK_CNT : SEARCH_WIN;
  localparam int MAX_CD = (SLIP_SETTLE > LOSS_WIN)
                        ? SLIP_SETTLE : LOSS_WIN;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] RUN_MAX     = CW'(CTRL_LOCK_CNT);
  localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_WIN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SLIP_SETTLE - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_WIN - 1);

  logic          is_ctrl;
  logic [1:0]    state_d, state_q;
  logic [CW-1:0] timer_d, timer_q;
  logic [CW-1:0] run_d,   run_q;

  tmds_symbol_decode u_dec (
    .clk_i     (I_pxl_clk),
    .rst_i     (I_rst),
    .sym_i     (I_sym),
    .is_ctrl_o (is_ctrl),
    .de_o      (O_de),
    .ctrl_o    (O_ctrl),
    .data_o    (O_data)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + ONE;
    run_d   = '0;
    if (is_ctrl) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + ONE;
    end
    unique case (state_q)
      SEARCH: begin
        // lock wins over a slip due in the same cycle
        if (run_d == RUN_MAX) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (timer_q == SEARCH_LAST) begin
          state_d = SLIP;
          timer_d = '0;
        end
      end
      SLIP: begin
        state_d = SETTLE;
        timer_d = '0;
      end
      SETTLE: begin
        run_d = '0;
        if (timer_q == SETTLE_LAST) begin
          state_d = SEARCH;
          timer_d = '0;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          timer_d = '0;
        end else if (timer_q == LOSS_LAST) begin
          state_d = SEARCH;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      state_q <= SEARCH;
      timer_q <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      run_q   <= run_d;
    end
  end

  assign O_bitslip = (state_q == SLIP);
  assign O_aligned = (state_q == LOCKED);

`ifdef TMDS_LOSS_CNT_EN
  logic [15:0] loss_d, loss_q;

  always_comb begin
    loss_d = loss_q;
    if (state_q == LOCKED && state_d == SEARCH
        && loss_q != 16'hFFFF) begin
      loss_d = loss_q + 16'd1;
    end
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) loss_q <= '0;
    else       loss_q <= loss_d;
  end

  assign O_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: decode, lock,
// slip search, slip/lock tie, loss of lock and reset in SETTLE.
module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       I_rst;
  logic [9:0] I_sym;
  logic       O_bitslip, O_aligned, O_de;
  logic [1:0] O_ctrl;
  logic [7:0] O_data;
`ifdef TMDS_LOSS_CNT_EN
  logic [15:0] O_loss_cnt;
`endif

  tmds_channel_decoder dut (
    .I_pxl_clk (clk),
    .I_rst     (I_rst),
    .I_sym     (I_sym),
    .O_bitslip (O_bitslip),
    .O_aligned (O_aligned),
    .O_de      (O_de),
    .O_ctrl    (O_ctrl),
    .O_data    (O_data)
`ifdef TMDS_LOSS_CNT_EN
    ,
    .O_loss_cnt (O_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  typedef struct {
    int         due;
    bit         de;
    bit         ck_ctrl;
    logic [1:0] ctrl;
    bit         ck_data;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  exp_t       me;
  logic [1:0] m_ctrl = '0;
  logic [7:0] m_data = '0;
  bit         k_ctrl = 1'b1;
  bit         k_data = 1'b1;

  // monitor: pop every expectation whose sampling edge has passed
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      me = sbq.pop_front();
      check("due_cycle", 16'(me.due), 16'(cyc));
      check("de", 16'(O_de), 16'(me.de));
      if (me.ck_ctrl) check("ctrl", 16'(O_ctrl), 16'(me.ctrl));
      if (me.ck_data) check("data", 16'(O_data), 16'(me.data));
    end
  end

  int slips = 0;
  always @(negedge clk) if (O_bitslip) slips++;

  // kind: 0 unknown, 1 ctrl (val = C1C0), 2 data (val = byte)
  task automatic drive(input logic [9:0] sym, input bit rst,
                       input int kind, input logic [7:0] val);
    exp_t e;
    I_sym = sym;
    I_rst = rst;
    if (rst) begin
      m_ctrl = '0; m_data = '0;
      k_ctrl = 1'b1; k_data = 1'b1;
    end else if (kind == 0) begin
      k_ctrl = 1'b0; k_data = 1'b0;
    end else begin
      if (kind == 1) begin m_ctrl = val[1:0]; k_ctrl = 1'b1; end
      else           begin m_data = val;      k_data = 1'b1; end
      e.due     = cyc + 1;
      e.de      = (kind == 2);
      e.ck_ctrl = k_ctrl;
      e.ctrl    = m_ctrl;
      e.ck_data = k_data;
      e.data    = m_data;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  int disp = 0;

  // reference TX encoder (transition minimise + DC balance)
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1, n0;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (disp == 0 || n1 == n0) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1 - n0;
    end
    return q;
  endfunction

  function automatic logic [9:0] tok_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  task automatic tok(input logic [1:0] c);
    disp = 0;
    drive(tok_sym(c), 1'b0, 1, {6'b0, c});
  endtask

  task automatic dat(input logic [7:0] b);
    drive(enc(b), 1'b0, 2, b);
  endtask

  task automatic do_reset(input int n);
    disp = 0;
    repeat (n) drive(10'b0, 1'b1, 0, 8'h00);
  endtask

  // deserializer model: serial bit queue, a slip drops one bit
  bit bq[$];
  int fpos = 0;

  task automatic refill();
    logic [9:0] s;
    while (bq.size() < 11) begin
      if (fpos < 100) begin disp = 0; s = 10'b1101010100; end
      else            s = enc(8'(fpos));
      fpos = (fpos == 299) ? 0 : fpos + 1;
      for (int b = 0; b < 10; b++) bq.push_back(s[b]);
    end
  endtask

  function automatic logic [9:0] take_word();
    logic [9:0] w;
    for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    return w;
  endfunction

  logic [9:0] wv;
  int         np, last;

  initial begin
    I_rst = 1'b1;
    I_sym = '0;

    // reset state
    do_reset(3);
    check("reset_outputs",
          16'({O_bitslip, O_aligned, O_de, O_ctrl, O_data}), 16'h0);

    // hand-decoded data symbols and the four control tokens
    drive(10'b0100000000, 1'b0, 2, 8'h00);
    drive(10'b1000000000, 1'b0, 2, 8'hFF);
    drive(10'b0111111111, 1'b0, 2, 8'h01);
    drive(10'b1101010100, 1'b0, 1, 8'h00);
    drive(10'b0010101011, 1'b0, 1, 8'h01);
    drive(10'b0101010100, 1'b0, 1, 8'h02);
    drive(10'b1010101011, 1'b0, 1, 8'h03);
    dat(8'h5A);
    tok(2'b10);

    // aligned stream
    do_reset(2);
    for (int k = 0; k < 100; k++) begin
      tok(2'b00);
      if (k == 62) check("lock_early", 16'(O_aligned), 16'h0);
      if (k == 63) check("lock_at_64", 16'(O_aligned), 16'h1);
    end
    for (int j = 0; j < 1280; j++) dat(8'(j));
    check("aligned_hold", 16'(O_aligned), 16'h1);

    // loss of lock
    do_reset(2);
    for (int k = 0; k < 64; k++) tok(2'b00);
    check("loss_locked", 16'(O_aligned), 16'h1);
    for (int j = 0; j < 8192; j++) begin
      dat(8'(j * 7));
      if (j == 8190) check("loss_early", 16'(O_aligned), 16'h1);
      if (j == 8191) check("loss_fall", 16'(O_aligned), 16'h0);
    end
`ifdef TMDS_LOSS_CNT_EN
    check("loss_cnt", O_loss_cnt, 16'h1);
`endif

    // lock and slip due on the same cycle
    do_reset(2);
    slips = 0;
    for (int i = 0; i < 4032; i++) dat(8'(i));
    for (int k = 0; k < 64; k++) begin
      tok(2'b11);
      if (k == 62) check("tie_pre", 16'(O_aligned), 16'h0);
      if (k == 63) check("tie_lock", 16'(O_aligned), 16'h1);
    end
    repeat (20) tok(2'b01);
    check("tie_no_slip", 16'(slips), 16'h0);

    // reset during SETTLE
    do_reset(2);
    slips = 0;
    for (int i = 0; i < 4096; i++) begin
      dat(8'(i + 3));
      if (i == 4094) check("slip_pre", 16'(O_bitslip), 16'h0);
      if (i == 4095) check("slip_first", 16'(O_bitslip), 16'h1);
    end
    repeat (3) dat(8'hC3);
    do_reset(1);
    check("rst_settle_out",
          16'({O_bitslip, O_aligned, O_de, O_ctrl, O_data}), 16'h0);
    slips = 0;
    for (int i = 0; i < 4096; i++) begin
      dat(8'(i));
      if (i == 4094) check("rst_no_slip", 16'(slips), 16'h0);
      if (i == 4095) check("rst_slip", 16'(O_bitslip), 16'h1);
    end

    // misaligned stream, rotated by 3 bits
    do_reset(2);
    slips = 0;
    np    = 0;
    last  = 0;
    bq.delete();
    fpos = 0;
    refill();
    repeat (3) void'(bq.pop_front());
    for (int i = 0; i < 30000; i++) begin
      refill();
      wv = take_word();
      drive(wv, 1'b0, 0, 8'h00);
      if (O_bitslip) begin
        if (np == 0) check("mis_first", 16'(i), 16'd4095);
        else         check("mis_gap", 16'(i - last), 16'd4105);
        np++;
        last = i;
        refill();
        void'(bq.pop_front());
      end
    end
    check("mis_pulses", 16'(np), 16'd7);
    check("mis_aligned", 16'(O_aligned), 16'h1);

    drive(10'b0, 1'b1, 0, 8'h00);
    drive(10'b0, 1'b1, 0, 8'h00);
    check("sb_drained", 16'(sbq.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
